wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Round-robin arbiter sharing one pipelined Wishbone slave (the register-file wb_slave) between NUM_MASTERS masters.
- A grant is held for a master's whole bus cycle (cyc high).
- Tracks outstanding requests, throttles at MAX_OUTSTANDING, and aborts a hung cycle with an error after a watchdog timeout.
- Sits between master-side bus functional models/CPUs and the wb_slave instance.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
ADDR_WIDTH, 16, Wishbone address width
DATA_WIDTH, 32, Wishbone data width
GRANULE, 8, bits per select lane
SEL_WIDTH, DATA_WIDTH/GRANULE, select width (localparam)
MAX_OUTSTANDING, 4, max accepted-but-unacknowledged requests
TIMEOUT_CYCLES, 256, cycles with no ack/err and outstanding>0 before abort

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
m_cyc_i  in  NUM_MASTERS  per-master cycle
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed selects
m_dat_o  out  DATA_WIDTH  read data, broadcast = s_dat_i
m_ack_o  out  NUM_MASTERS  ack, only to granted master
m_err_o  out  NUM_MASTERS  err, only to granted master
m_stall_o  out  NUM_MASTERS  stall
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_sel_o  out  SEL_WIDTH  slave select
s_dat_i  in  DATA_WIDTH  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err
s_stall_i  in  1  slave stall
gnt_o  out  NUM_MASTERS  one-hot current grant (0 when idle)

Behaviour:
- Reset (async): state=IDLE, gnt=0, last_grant=NUM_MASTERS-1, outstanding=0, timer=0.
- Reset output values: s_cyc_o=s_stb_o=0; m_ack_o=m_err_o=0; m_stall_o=all ones.
- Reset mid-cycle drops s_cyc_o in the same cycle (async); no ack is forwarded after reset.
- States: IDLE, BUSY, ABORT.
- IDLE: if any m_cyc_i is high, pick the first requester searching from last_grant+1 upward with wrap. The grant is registered; go BUSY. Grant latency is 1 cycle from cyc. No outputs toward the slave while in IDLE.
- BUSY (granted g):
  - s_cyc_o=m_cyc_i[g].
  - s_stb_o=m_stb_i[g] & ~full, where full = (outstanding==MAX_OUTSTANDING).
  - s_we/adr/dat/sel are muxed from g.
  - m_stall_o[g]=s_stall_i | full; all other m_stall_o=1.
  - m_ack_o[g]=s_ack_i; m_err_o[g]=s_err_i.
- Outstanding counter:
  - +1 on (s_stb_o & ~s_stall_i); -1 on (s_ack_i|s_err_i); both in the same cycle gives net 0.
  - Never exceeds MAX_OUTSTANDING.
  - ack/err with outstanding==0 is dropped (not forwarded) and the counter saturates at 0.
- m_cyc_i[g] falls in BUSY: last_grant<=g, outstanding<=0, timer<=0, go IDLE. Earliest regrant is 2 cycles after the cyc drop, and another requester wins first if pending (fairness).
- Watchdog:
  - Timer counts while BUSY and outstanding>0; cleared on any ack/err or when outstanding==0.
  - At timer==TIMEOUT_CYCLES-1: m_err_o[g]=1 for exactly one cycle, s_cyc_o=0 from the next cycle, go ABORT.
- ABORT: s_cyc_o=s_stb_o=0, m_stall_o[g]=1, slave ack/err ignored. Exit to IDLE when m_cyc_i[g]=0, with last_grant<=g.
- Sole requester: it is regranted after its cyc drops and re-rises (round-robin wraps to itself).

Decomposition:
- Package wb_pkg: ADDR_WIDTH, DATA_WIDTH, GRANULE, SEL_WIDTH constants; arb_state_t enum {IDLE,BUSY,ABORT}.
- Sub-module wb_rr_pick: combinational round-robin picker (req vector, last_grant index -> one-hot grant + valid).

Test Plan:
- Masters 0 and 2 raise cyc together after reset -> gnt_o=0001 one cycle later. After m0 drops cyc, gnt_o=0100. Then m0 again, not m2 twice.
- m1 issues 6 back-to-back stb with slave acking 3 cycles late, MAX_OUTSTANDING=4 -> s_stb_o held low and m_stall_o[1]=1 while outstanding==4. All 6 acks reach m_ack_o[1] only.
- Granted m3 reads 0x0004, slave returns 0xDEADBEEF -> m_dat_o=0xDEADBEEF with m_ack_o=1000. m_ack_o and m_err_o for masters 0..2 stay 0.
- Slave never acks a read, TIMEOUT_CYCLES=16 -> m_err_o[g] pulses for exactly 1 cycle 16 cycles after the last accept; s_cyc_o then 0. A late s_ack_i during ABORT is not forwarded.
- rst_i asserted mid-burst with 2 outstanding -> s_cyc_o=0 and m_stall_o=1111 immediately; after release, first grant goes to m0 when all request.
- Spurious s_ack_i while idle/outstanding==0 -> no m_ack_o, counter remains 0.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone constants and the arbiter state encoding.
//   ADDR_WIDTH / DATA_WIDTH : default bus widths
//   GRANULE                 : bits carried by one select lane
//   SEL_WIDTH               : number of select lanes on the data bus
//   arb_state_t             : IDLE (no owner), BUSY (owner on the bus),
//                             ABORT (owner cut off by the watchdog)
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 32;
   localparam int GRANULE    = 8;
   localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ABORT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// ---------------------------------------------------------------------------
// wb_rr_pick
// Combinational round-robin picker. Searches the request vector starting
// one position above the previous winner and wrapping around, so the
// previous winner is considered last.
// Ports:
//   req        : per-master request vector
//   last_grant : index of the previous winner
//   gnt        : one-hot winner (all zero when nothing requests)
//   gnt_idx    : index of the winner
//   valid      : at least one master requests
// ---------------------------------------------------------------------------
module wb_rr_pick
   import wb_pkg::*;
#(
   parameter int  NUM_MASTERS = 4,
   localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       last_grant,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic [IDX_W-1:0]       gnt_idx,
   output logic                   valid
);

   // Walk the masters from last_grant+1 upward with wrap; the first one
   // found requesting wins and later candidates are ignored. Offset
   // NUM_MASTERS lands back on last_grant itself, which is how a sole
   // requester gets regranted.
   always_comb begin
      logic [IDX_W-1:0] cand;
      gnt     = '0;
      gnt_idx = '0;
      valid   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand = IDX_W'((int'(last_grant) + i) % NUM_MASTERS);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Round-robin arbiter sharing one pipelined Wishbone slave between
// NUM_MASTERS masters. A master keeps the bus for its whole cycle (cyc
// high). Accepted-but-unanswered requests are counted and new strobes are
// throttled at MAX_OUTSTANDING. A watchdog errors out a cycle whose slave
// stops answering for TIMEOUT_CYCLES.
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i  : per-master control bits
//   m_adr_i/m_dat_i/m_sel_i : packed per-master address/data/select
//   m_dat_o                 : read data broadcast to all masters
//   m_ack_o/m_err_o         : response, routed to the granted master only
//   m_stall_o               : per-master stall (ones for non-owners)
//   s_*_o                   : request toward the slave
//   s_dat_i/s_ack_i/s_err_i/s_stall_i : slave response
//   gnt_o                   : one-hot current owner, zero when idle
// ---------------------------------------------------------------------------
module wb_arbiter #(
   parameter int  NUM_MASTERS     = 4,
   parameter int  ADDR_WIDTH      = wb_pkg::ADDR_WIDTH,
   parameter int  DATA_WIDTH      = wb_pkg::DATA_WIDTH,
   parameter int  GRANULE         = wb_pkg::GRANULE,
   parameter int  MAX_OUTSTANDING = 4,
   parameter int  TIMEOUT_CYCLES  = 256,
   localparam int SEL_WIDTH       = DATA_WIDTH / GRANULE
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_MASTERS-1:0]            m_cyc_i,
   input  logic [NUM_MASTERS-1:0]            m_stb_i,
   input  logic [NUM_MASTERS-1:0]            m_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
   input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
   output logic [DATA_WIDTH-1:0]             m_dat_o,
   output logic [NUM_MASTERS-1:0]            m_ack_o,
   output logic [NUM_MASTERS-1:0]            m_err_o,
   output logic [NUM_MASTERS-1:0]            m_stall_o,
   output logic                              s_cyc_o,
   output logic                              s_stb_o,
   output logic                              s_we_o,
   output logic [ADDR_WIDTH-1:0]             s_adr_o,
   output logic [DATA_WIDTH-1:0]             s_dat_o,
   output logic [SEL_WIDTH-1:0]              s_sel_o,
   input  logic [DATA_WIDTH-1:0]             s_dat_i,
   input  logic                              s_ack_i,
   input  logic                              s_err_i,
   input  logic                              s_stall_i,
   output logic [NUM_MASTERS-1:0]            gnt_o
);

   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   wb_pkg::arb_state_t     state;
   logic [NUM_MASTERS-1:0] gnt;
   logic [IDX_W-1:0]       g_idx;
   logic [IDX_W-1:0]       last_grant;
   logic [OUT_W-1:0]       outstanding;
   logic [TMR_W-1:0]       timer;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;

   logic [ADDR_WIDTH-1:0]  adr_arr [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]  dat_arr [NUM_MASTERS];
   logic [SEL_WIDTH-1:0]   sel_arr [NUM_MASTERS];

   logic busy;
   logic cur_cyc;
   logic full;
   logic has_out;
   logic resp;
   logic accept;
   logic timeout;

   // The packed per-master buses are split into arrays so the owner's
   // fields can be selected by index.
   always_comb begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
         adr_arr[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
         dat_arr[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
         sel_arr[k] = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
      end
   end

   wb_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_pick (
      .req        (m_cyc_i),
      .last_grant (last_grant),
      .gnt        (pick_gnt),
      .gnt_idx    (pick_idx),
      .valid      (pick_valid)
   );

   // A response only counts when something is actually outstanding;
   // stray acks/errs are swallowed so the counter cannot underflow.
   // The watchdog fires on the cycle the timer reaches its last value.
   assign busy    = (state == wb_pkg::BUSY);
   assign cur_cyc = m_cyc_i[g_idx];
   assign full    = (outstanding == OUT_W'(MAX_OUTSTANDING));
   assign has_out = (outstanding != '0);
   assign resp    = busy & (s_ack_i | s_err_i) & has_out;
   assign timeout = busy & has_out & (timer == TMR_W'(TIMEOUT_CYCLES - 1));
   assign accept  = s_stb_o & ~s_stall_i;

   // Slave-side request: only driven while an owner is BUSY, so IDLE,
   // ABORT and an asynchronous reset all drop cyc/stb immediately.
   assign s_cyc_o = busy & cur_cyc;
   assign s_stb_o = busy & m_stb_i[g_idx] & ~full;
   assign s_we_o  = busy & m_we_i[g_idx];
   assign s_adr_o = busy ? adr_arr[g_idx] : '0;
   assign s_dat_o = busy ? dat_arr[g_idx] : '0;
   assign s_sel_o = busy ? sel_arr[g_idx] : '0;

   // Master-side response: read data is broadcast, while ack/err/stall are
   // steered with the one-hot grant so non-owners never see a response
   // and always see stall.
   assign m_dat_o   = s_dat_i;
   assign m_ack_o   = gnt & {NUM_MASTERS{busy & s_ack_i & has_out}};
   assign m_err_o   = gnt & {NUM_MASTERS{busy & ((s_err_i & has_out) | timeout)}};
   assign m_stall_o = busy ? ~(gnt & {NUM_MASTERS{~(s_stall_i | full)}}) : '1;
   assign gnt_o     = gnt;

   // Arbitration FSM with the outstanding counter and watchdog timer.
   // Dropping cyc always wins: the owner becomes last_grant so the next
   // search starts above it, and all bookkeeping is cleared. A timeout
   // moves to ABORT, where the owner is held off the bus until it lets go
   // of cyc. An accept and a response in the same cycle cancel out.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= wb_pkg::IDLE;
         gnt         <= '0;
         g_idx       <= '0;
         last_grant  <= IDX_W'(NUM_MASTERS - 1);
         outstanding <= '0;
         timer       <= '0;
      end else begin
         unique case (state)
            wb_pkg::IDLE: begin
               outstanding <= '0;
               timer       <= '0;
               if (pick_valid) begin
                  gnt   <= pick_gnt;
                  g_idx <= pick_idx;
                  state <= wb_pkg::BUSY;
               end
            end
            wb_pkg::BUSY: begin
               if (!cur_cyc) begin
                  last_grant  <= g_idx;
                  gnt         <= '0;
                  outstanding <= '0;
                  timer       <= '0;
                  state       <= wb_pkg::IDLE;
               end else if (timeout) begin
                  outstanding <= '0;
                  timer       <= '0;
                  state       <= wb_pkg::ABORT;
               end else begin
                  if (accept && !resp) begin
                     outstanding <= outstanding + OUT_W'(1);
                  end else if (!accept && resp) begin
                     outstanding <= outstanding - OUT_W'(1);
                  end
                  if (resp || !has_out) begin
                     timer <= '0;
                  end else begin
                     timer <= timer + TMR_W'(1);
                  end
               end
            end
            wb_pkg::ABORT: begin
               if (!cur_cyc) begin
                  last_grant <= g_idx;
                  gnt        <= '0;
                  state      <= wb_pkg::IDLE;
               end
            end
            default: begin
               state <= wb_pkg::IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter with four masters, MAX_OUTSTANDING=4 and a
// short watchdog (TIMEOUT_CYCLES=16). The slave is played by the stimulus
// itself. Inputs change 1 time unit after a rising edge and outputs are
// checked 1 time unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

   logic          clk;
   logic          rst;
   logic [3:0]    m_cyc;
   logic [3:0]    m_stb;
   logic [3:0]    m_we;
   logic [63:0]   m_adr;
   logic [127:0]  m_dat;
   logic [15:0]   m_sel;
   logic [31:0]   m_dat_o;
   logic [3:0]    m_ack_o;
   logic [3:0]    m_err_o;
   logic [3:0]    m_stall_o;
   logic          s_cyc_o;
   logic          s_stb_o;
   logic          s_we_o;
   logic [15:0]   s_adr_o;
   logic [31:0]   s_dat_o;
   logic [3:0]    s_sel_o;
   logic [31:0]   s_dat_i;
   logic          s_ack;
   logic          s_err;
   logic          s_stall;
   logic [3:0]    gnt_o;

   int tests_run;
   int tests_failed;

   logic [16:0] b_stb;
   logic [16:0] b_ack;
   logic [16:0] b_sstb;
   logic [16:0] b_stall1;
   logic [16:0] b_ack1;

   wb_arbiter #(
      .NUM_MASTERS     (4),
      .ADDR_WIDTH      (16),
      .DATA_WIDTH      (32),
      .GRANULE         (8),
      .MAX_OUTSTANDING (4),
      .TIMEOUT_CYCLES  (16)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .m_cyc_i   (m_cyc),
      .m_stb_i   (m_stb),
      .m_we_i    (m_we),
      .m_adr_i   (m_adr),
      .m_dat_i   (m_dat),
      .m_sel_i   (m_sel),
      .m_dat_o   (m_dat_o),
      .m_ack_o   (m_ack_o),
      .m_err_o   (m_err_o),
      .m_stall_o (m_stall_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_sel_o   (s_sel_o),
      .s_dat_i   (s_dat_i),
      .s_ack_i   (s_ack),
      .s_err_i   (s_err),
      .s_stall_i (s_stall),
      .gnt_o     (gnt_o)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive master control bits and the slave response, then let the
   // combinational paths settle before anything is checked.
   task automatic applyStimulus(input logic [3:0] cyc, input logic [3:0] stb,
                                input logic ack, input logic err, input logic stall);
      m_cyc   = cyc;
      m_stb   = stb;
      s_ack   = ack;
      s_err   = err;
      s_stall = stall;
      #1;
   endtask

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Directed scenario sequence: reset, fairness, throttling, routed read,
   // watchdog abort, reset mid-burst.
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst     = 1'b1;
      m_we    = 4'b0000;
      m_adr   = {16'h0004, 16'h0CCC, 16'h0BBB, 16'h0AAA};
      m_dat   = {32'hCAFEF00D, 32'h33333333, 32'h22222222, 32'h11111111};
      m_sel   = 16'hF000;
      s_dat_i = 32'h0;

      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      checkOutput("reset s_cyc", 64'(s_cyc_o), 64'd0);
      checkOutput("reset s_stb", 64'(s_stb_o), 64'd0);
      checkOutput("reset m_ack", 64'(m_ack_o), 64'h0);
      checkOutput("reset m_err", 64'(m_err_o), 64'h0);
      checkOutput("reset m_stall", 64'(m_stall_o), 64'hF);
      checkOutput("reset gnt", 64'(gnt_o), 64'h0);
      nextCycle();
      rst = 1'b0;

      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      checkOutput("idle spurious ack", 64'(m_ack_o), 64'h0);
      nextCycle();

      applyStimulus(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
      checkOutput("A gnt latency", 64'(gnt_o), 64'h0);
      checkOutput("A idle s_cyc", 64'(s_cyc_o), 64'd0);
      nextCycle();
      checkOutput("A first gnt m0", 64'(gnt_o), 64'b0001);
      checkOutput("A s_cyc m0", 64'(s_cyc_o), 64'd1);
      checkOutput("A stall m0", 64'(m_stall_o), 64'b1110);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
      checkOutput("A s_cyc drop", 64'(s_cyc_o), 64'd0);
      nextCycle();
      checkOutput("A idle after drop", 64'(gnt_o), 64'h0);
      nextCycle();
      checkOutput("A gnt m2", 64'(gnt_o), 64'b0100);
      applyStimulus(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();
      nextCycle();
      checkOutput("A gnt back to m0", 64'(gnt_o), 64'b0001);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();

      // Throttling table for m1, one bit per cycle c0..c16 (bit i = cycle i).
      // Acks come 4 cycles after each accept; c11 is a stray ack at zero
      // outstanding, then four fresh accepts must fill the window at c16.
      b_stb    = 17'b11111_00000_1111111;
      b_ack    = 17'b00000_11101_1110000;
      b_sstb   = 17'b01111_00000_1101111;
      b_stall1 = 17'b10000_00000_0010000;
      b_ack1   = 17'b00000_01101_1110000;
      applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("B gnt m1", 64'(gnt_o), 64'b0010);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(4'b0010, {2'b00, b_stb[i], 1'b0}, b_ack[i], 1'b0, 1'b0);
         checkOutput($sformatf("B s_stb c%0d", i), 64'(s_stb_o), 64'(b_sstb[i]));
         checkOutput($sformatf("B m_stall c%0d", i), 64'(m_stall_o),
                     64'({2'b11, b_stall1[i], 1'b1}));
         checkOutput($sformatf("B m_ack c%0d", i), 64'(m_ack_o),
                     64'({2'b00, b_ack1[i], 1'b0}));
         nextCycle();
      end
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();

      applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("C gnt m3", 64'(gnt_o), 64'b1000);
      applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0);
      checkOutput("C s_stb", 64'(s_stb_o), 64'd1);
      checkOutput("C s_we", 64'(s_we_o), 64'd0);
      checkOutput("C s_adr", 64'(s_adr_o), 64'h0004);
      checkOutput("C s_sel", 64'(s_sel_o), 64'hF);
      checkOutput("C s_dat", 64'(s_dat_o), 64'hCAFEF00D);
      nextCycle();
      s_dat_i = 32'hDEADBEEF;
      applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0);
      checkOutput("C m_dat", 64'(m_dat_o), 64'hDEADBEEF);
      checkOutput("C m_ack", 64'(m_ack_o), 64'b1000);
      checkOutput("C m_err", 64'(m_err_o), 64'h0);
      nextCycle();
      s_dat_i = 32'h0;
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();

      applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("D gnt m0", 64'(gnt_o), 64'b0001);
      applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
      checkOutput("D accept", 64'(s_stb_o), 64'd1);
      nextCycle();
      for (int k = 1; k <= 15; k++) begin
         applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("D no err a%0d", k), 64'(m_err_o), 64'h0);
         nextCycle();
      end
      checkOutput("D timeout err", 64'(m_err_o), 64'b0001);
      checkOutput("D s_cyc at timeout", 64'(s_cyc_o), 64'd1);
      nextCycle();
      applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
      checkOutput("D err one cycle", 64'(m_err_o), 64'h0);
      checkOutput("D abort s_cyc", 64'(s_cyc_o), 64'd0);
      checkOutput("D abort stall", 64'(m_stall_o), 64'hF);
      checkOutput("D late ack dropped", 64'(m_ack_o), 64'h0);
      nextCycle();
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();

      applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("E gnt m1", 64'(gnt_o), 64'b0010);
      applyStimulus(4'b1111, 4'b0010, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(4'b1111, 4'b0010, 1'b0, 1'b0, 1'b0);
      checkOutput("E s_cyc before rst", 64'(s_cyc_o), 64'd1);
      nextCycle();
      rst = 1'b1;
      applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
      checkOutput("E rst s_cyc", 64'(s_cyc_o), 64'd0);
      checkOutput("E rst m_stall", 64'(m_stall_o), 64'hF);
      checkOutput("E rst gnt", 64'(gnt_o), 64'h0);
      checkOutput("E rst m_ack", 64'(m_ack_o), 64'h0);
      nextCycle();
      rst = 1'b0;
      applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("E gnt m0 after rst", 64'(gnt_o), 64'b0001);
      applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
      checkOutput("E ack at zero outstanding", 64'(m_ack_o), 64'h0);
      nextCycle();
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      nextCycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
